serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 88 ++++++++
 tb/tb_serial_adder.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
//   master: drives start, sub, a, b, cin; observes ready, busy, done, sum, carry_out, overflow
//   slave : the adder side of the same signals
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;
    modport master (
        output start, sub, cin, a, b,
        input  ready, busy, done, sum, carry_out, overflow
    );
    modport slave (
        input  start, sub, cin, a, b,
        output ready, busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial add/subtract through one full-adder cell and a carry FF.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if slave (start/sub/a/b/cin in; ready/busy/done/sum/carry_out/overflow out)
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic          clk,
    input logic          rst_n,
    serial_adder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [WIDTH-2:0] ps_q, ps_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d, co_q, co_d, ov_q, ov_d;
    logic             s, c_nxt, last;
    assign s     = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nxt = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    assign last  = cnt_q == CNT_W'(WIDTH - 1);
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ps_d    = ps_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ov_d    = ov_q;
        case (state_q)
            IDLE: if (bus.start) begin
                a_d     = bus.a;
                b_d     = bus.sub ? ~bus.b : bus.b;
                c_d     = bus.sub | bus.cin;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                // partial sum keeps the WIDTH-1 low bits; the MSB joins them directly at the last edge
                ps_d  = (ps_q >> 1) | ((WIDTH - 1)'(s) << (WIDTH - 2));
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = c_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    // at the MSB edge c_q is the latched carry into the MSB
                    sum_d   = {s, ps_q};
                    co_d    = c_nxt;
                    ov_d    = c_q ^ c_nxt;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end
    assign bus.ready     = state_q == IDLE;
    assign bus.busy      = state_q == RUN;
    assign bus.done      = state_q == DONE;
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
    assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks an 8-bit and a 3-bit serial_adder against an arithmetic reference model.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(3)) if3 ();
    serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder #(.WIDTH(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    logic       d_start[2], d_sub[2], d_cin[2];
    logic [7:0] d_a[2], d_b[2];
    logic       o_ready[2], o_busy[2], o_done[2], o_co[2], o_ov[2];
    logic [7:0] o_sum[2];

    assign if8.start = d_start[0];
    assign if8.sub   = d_sub[0];
    assign if8.cin   = d_cin[0];
    assign if8.a     = d_a[0];
    assign if8.b     = d_b[0];
    assign if3.start = d_start[1];
    assign if3.sub   = d_sub[1];
    assign if3.cin   = d_cin[1];
    assign if3.a     = d_a[1][2:0];
    assign if3.b     = d_b[1][2:0];
    assign o_ready[0] = if8.ready;
    assign o_busy[0]  = if8.busy;
    assign o_done[0]  = if8.done;
    assign o_sum[0]   = if8.sum;
    assign o_co[0]    = if8.carry_out;
    assign o_ov[0]    = if8.overflow;
    assign o_ready[1] = if3.ready;
    assign o_busy[1]  = if3.busy;
    assign o_done[1]  = if3.done;
    assign o_sum[1]   = {5'b0, if3.sum};
    assign o_co[1]    = if3.carry_out;
    assign o_ov[1]    = if3.overflow;

    function automatic int wid(input int i);
        return i == 0 ? 8 : 3;
    endfunction

    // {overflow, carry_out, sum} from plain integer arithmetic
    function automatic logic [9:0] ref_op(input int w, input int a, input int b, input bit cin, input bit sub);
        int m, x, y, full, s;
        bit co, ov;
        m    = (1 << w) - 1;
        x    = a & m;
        y    = (sub ? ~b : b) & m;
        full = x + y + (sub ? 1 : int'(cin));
        s    = full & m;
        co   = ((full >> w) & 1) != 0;
        ov   = (((x >> (w - 1)) & 1) == ((y >> (w - 1)) & 1)) && (((s >> (w - 1)) & 1) != ((x >> (w - 1)) & 1));
        return {ov, co, s[7:0]};
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // transaction-level model: mode 0 idle, 1 run, 2 done
    int         m_mode[2], m_cnt[2];
    logic [9:0] m_pend[2];
    logic [7:0] m_sum[2];
    logic       m_co[2], m_ov[2];
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_mode[i] <= 0;
                m_cnt[i]  <= 0;
                m_pend[i] <= '0;
                m_sum[i]  <= '0;
                m_co[i]   <= 1'b0;
                m_ov[i]   <= 1'b0;
            end else if (m_mode[i] == 0) begin
                if (d_start[i]) begin
                    m_pend[i] <= ref_op(wid(i), int'(d_a[i]), int'(d_b[i]), d_cin[i], d_sub[i]);
                    m_cnt[i]  <= 1;
                    m_mode[i] <= 1;
                end
            end else if (m_mode[i] == 1) begin
                if (m_cnt[i] == wid(i)) begin
                    {m_ov[i], m_co[i], m_sum[i]} <= m_pend[i];
                    m_mode[i] <= 2;
                end else m_cnt[i] <= m_cnt[i] + 1;
            end else m_mode[i] <= 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready%0d", i), o_ready[i], m_mode[i] == 0);
            chk($sformatf("busy%0d", i), o_busy[i], m_mode[i] == 1);
            chk($sformatf("done%0d", i), o_done[i], m_mode[i] == 2);
            chk($sformatf("sum%0d", i), o_sum[i], m_sum[i]);
            chk($sformatf("carry%0d", i), o_co[i], m_co[i]);
            chk($sformatf("ovf%0d", i), o_ov[i], m_ov[i]);
        end
    end

    task automatic op(input int i, input int a, input int b, input bit cin, input bit sub,
                      output int rsum, output int rco, output int rov, output int nbusy);
        int t;
        @(negedge clk);
        for (t = 0; t < 50 && !o_ready[i]; t++) @(negedge clk);
        d_a[i] = 8'(a);
        d_b[i] = 8'(b);
        d_cin[i] = cin;
        d_sub[i] = sub;
        d_start[i] = 1'b1;
        @(posedge clk);
        #1;
        d_start[i] = 1'b0;
        d_a[i] = 8'($urandom);
        d_b[i] = 8'($urandom);
        d_cin[i] = 1'($urandom);
        nbusy = 0;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (o_done[i]) break;
            if (o_busy[i]) nbusy++;
        end
        chk($sformatf("done_seen%0d", i), o_done[i], 1);
        rsum = int'(o_sum[i]);
        rco  = int'(o_co[i]);
        rov  = int'(o_ov[i]);
    endtask

    int       rs, rc, rv, nb, n;
    logic [9:0] e;
    initial begin
        for (int i = 0; i < 2; i++) begin
            d_start[i] = 0; d_sub[i] = 0; d_cin[i] = 0; d_a[i] = 0; d_b[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready[0], 1);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_sum", o_sum[0], 0);
        rst_n = 1'b1;

        op(0, 8'h0F, 8'h01, 0, 0, rs, rc, rv, nb);
        chk("add0f_sum", rs, 8'h10); chk("add0f_co", rc, 0); chk("add0f_ov", rv, 0); chk("add0f_busy", nb, 8);
        op(0, 8'hFF, 8'h01, 1, 0, rs, rc, rv, nb);
        chk("addff_sum", rs, 8'h01); chk("addff_co", rc, 1); chk("addff_ov", rv, 0); chk("addff_busy", nb, 8);
        op(0, 8'h7F, 8'h01, 0, 0, rs, rc, rv, nb);
        chk("add7f_sum", rs, 8'h80); chk("add7f_co", rc, 0); chk("add7f_ov", rv, 1);
        op(0, 8'h05, 8'h07, 1, 1, rs, rc, rv, nb);
        chk("sub05_sum", rs, 8'hFE); chk("sub05_co", rc, 0); chk("sub05_ov", rv, 0);
        op(0, 8'h80, 8'h01, 0, 1, rs, rc, rv, nb);
        chk("sub80_sum", rs, 8'h7F); chk("sub80_co", rc, 1); chk("sub80_ov", rv, 1);

        // asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sum", o_sum[0], 0); chk("arst_co", o_co[0], 0); chk("arst_ov", o_ov[0], 0);
        chk("arst_ready", o_ready[0], 1); chk("arst_busy", o_busy[0], 0); chk("arst_done", o_done[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // start held high across RUN and DONE; operands change mid-run
        @(negedge clk);
        d_a[0] = 8'h01; d_b[0] = 8'h02; d_cin[0] = 0; d_sub[0] = 0; d_start[0] = 1'b1;
        @(posedge clk);
        #1 d_a[0] = 8'h10; d_b[0] = 8'h20;
        for (n = 0; n < 30 && !o_done[0]; n++) @(negedge clk);
        chk("hold_first_sum", o_sum[0], 8'h03);
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (o_done[0]) break;
        end
        d_start[0] = 1'b0;
        chk("hold_spacing", n + 1, 10);
        chk("hold_second_sum", o_sum[0], 8'h30);

        // reset during the 3rd RUN cycle
        @(negedge clk);
        d_a[0] = 8'h33; d_b[0] = 8'h11; d_start[0] = 1'b1;
        @(posedge clk);
        #1 d_start[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("midrst_sum", o_sum[0], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("midrst_nodone", o_done[0], 0);
        end
        chk("midrst_norestore", o_sum[0], 0);

        // 3-bit: hand-computed cases, then every operand combination
        op(1, 3, 1, 0, 0, rs, rc, rv, nb);
        chk("w3_add_sum", rs, 4); chk("w3_add_ov", rv, 1); chk("w3_add_co", rc, 0);
        op(1, 2, 5, 0, 1, rs, rc, rv, nb);
        chk("w3_sub_sum", rs, 5); chk("w3_sub_co", rc, 0); chk("w3_sub_ov", rv, 1);
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    for (int s = 0; s < 2; s++) begin
                        op(1, a, b, c[0], s[0], rs, rc, rv, nb);
                        e = ref_op(3, a, b, c[0], s[0]);
                        chk($sformatf("w3 a=%0d b=%0d c=%0d s=%0d", a, b, c, s), {rv[0], rc[0], rs[7:0]}, e);
                        chk("w3_busy_cycles", nb, 3);
                    end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
